// File: rtl/fft_stream_wrap.sv
// Serial<->parallel streaming wrapper around a LEN-lane FFT core, with a two-bank output buffer.
// Define FFT_BITREV_OUT_EN to replay lanes in bit-reversed order (natural output from a bitrev core).
module fft_stream_wrap #(
   parameter int DATA_WID = 16,
   parameter int LOG2_LEN = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WID-1:0]          in_re,
   input  logic [DATA_WID-1:0]          in_im,
   output logic                         core_val_o,
   output logic [(2**LOG2_LEN)*DATA_WID-1:0] core_re_o,
   output logic [(2**LOG2_LEN)*DATA_WID-1:0] core_im_o,
   input  logic                         core_done_i,
   input  logic [(2**LOG2_LEN)*DATA_WID-1:0] core_re_i,
   input  logic [(2**LOG2_LEN)*DATA_WID-1:0] core_im_i,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WID-1:0]          out_re,
   output logic [DATA_WID-1:0]          out_im,
   output logic                         out_last,
   output logic                         err_o
);

   localparam int LEN = 2**LOG2_LEN;
   localparam logic [LOG2_LEN-1:0] LAST = LOG2_LEN'(LEN-1);

   // state    | meaning
   // S_IDLE   | no frame being replayed, waiting for bank rd_sel to fill
   // S_STREAM | out registers hold a valid sample of bank rd_sel
   typedef enum logic {S_IDLE, S_STREAM} state_t;

   function automatic logic [LOG2_LEN-1:0] lane_of(input logic [LOG2_LEN-1:0] k);
`ifdef FFT_BITREV_OUT_EN
      logic [LOG2_LEN-1:0] r;
      for (int i = 0; i < LOG2_LEN; i++) r[i] = k[LOG2_LEN-1-i];
      return r;
`else
      return k;
`endif
   endfunction

   logic [LOG2_LEN-1:0] in_cnt;
   logic [1:0]          credits;
   logic [DATA_WID-1:0] gather_re [LEN];
   logic [DATA_WID-1:0] gather_im [LEN];
   logic                in_beat;
   logic                drain;

   assign in_ready = !(in_cnt == '0 && credits == 2'd0);
   assign in_beat  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (in_beat && in_cnt != LAST) begin
         gather_re[in_cnt] <= in_re;
         gather_im[in_cnt] <= in_im;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_cnt     <= '0;
         core_val_o <= 1'b0;
         core_re_o  <= '0;
         core_im_o  <= '0;
      end else begin
         core_val_o <= in_beat && (in_cnt == LAST);
         if (in_beat) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == LAST) begin
               for (int k = 0; k < LEN-1; k++) begin
                  core_re_o[k*DATA_WID +: DATA_WID] <= gather_re[k];
                  core_im_o[k*DATA_WID +: DATA_WID] <= gather_im[k];
               end
               core_re_o[(LEN-1)*DATA_WID +: DATA_WID] <= in_re;
               core_im_o[(LEN-1)*DATA_WID +: DATA_WID] <= in_im;
            end
         end
      end
   end

   // A credit is a reserved output bank; taken at frame start, returned when that bank drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= 2'd2;
      end else begin
         case ({in_beat && (in_cnt == '0), drain})
            2'b10:   credits <= credits - 2'd1;
            2'b01:   credits <= credits + 2'd1;
            default: credits <= credits;
         endcase
      end
   end

   logic [DATA_WID-1:0] bank_re [2][LEN];
   logic [DATA_WID-1:0] bank_im [2][LEN];
   logic [1:0]          full;
   logic                wr_sel;
   logic                rd_sel;
   logic                capture;
   logic [1:0]          set_mask;
   logic [1:0]          clr_mask;

   assign capture  = core_done_i && !full[wr_sel];
   assign set_mask = capture ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
   assign clr_mask = drain   ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (capture) begin
         for (int k = 0; k < LEN; k++) begin
            bank_re[wr_sel][k] <= core_re_i[k*DATA_WID +: DATA_WID];
            bank_im[wr_sel][k] <= core_im_i[k*DATA_WID +: DATA_WID];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full   <= 2'b00;
         wr_sel <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         full <= (full & ~clr_mask) | set_mask;
         if (capture) wr_sel <= ~wr_sel;
         if (core_done_i && full[wr_sel]) err_o <= 1'b1;
      end
   end

   state_t              state, state_nxt;
   logic [LOG2_LEN-1:0] out_cnt;
   logic                load;
   logic                load_sel;
   logic [LOG2_LEN-1:0] load_cnt;
   logic                valid_nxt;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_sel  = rd_sel;
      load_cnt  = '0;
      valid_nxt = out_valid;
      drain     = 1'b0;
      case (state)
         S_IDLE: begin
            if (full[rd_sel]) begin
               load      = 1'b1;
               valid_nxt = 1'b1;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (!out_valid || out_ready) begin
               if (out_last) begin
                  drain = 1'b1;
                  if (full[~rd_sel]) begin
                     load     = 1'b1;
                     load_sel = ~rd_sel;
                  end else begin
                     valid_nxt = 1'b0;
                     state_nxt = S_IDLE;
                  end
               end else begin
                  load     = 1'b1;
                  load_cnt = out_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_cnt   <= '0;
         rd_sel    <= 1'b0;
      end else begin
         out_valid <= valid_nxt;
         if (drain) rd_sel <= ~rd_sel;
         if (load) begin
            out_cnt <= load_cnt;
            out_re  <= bank_re[load_sel][lane_of(load_cnt)];
            out_im  <= bank_im[load_sel][lane_of(load_cnt)];
         end
      end
   end

   assign out_last = out_valid && (out_cnt == LAST);

endmodule

// File: tb/tb_fft_stream_wrap.sv
// Directed bench for fft_stream_wrap (LEN=16): packing, replay order, back-to-back, credits, overflow, reset.
module tb_fft_stream_wrap;
   localparam int DW  = 16;
   localparam int LG  = 4;
   localparam int LEN = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready;
   logic [DW-1:0]     in_re, in_im;
   logic              core_val_o;
   logic [LEN*DW-1:0] core_re_o, core_im_o;
   logic              core_done_i;
   logic [LEN*DW-1:0] core_re_i, core_im_i;
   logic              out_valid, out_ready, out_last, err_o;
   logic [DW-1:0]     out_re, out_im;

   int n_cmp = 0;
   int n_err = 0;
   int val_cnt = 0;
   int snap;

   fft_stream_wrap #(.DATA_WID(DW), .LOG2_LEN(LG)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .core_val_o(core_val_o), .core_re_o(core_re_o), .core_im_o(core_im_o),
      .core_done_i(core_done_i), .core_re_i(core_re_i), .core_im_i(core_im_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_last(out_last), .err_o(err_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (core_val_o) val_cnt <= val_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lane_of(input int k);
`ifdef FFT_BITREV_OUT_EN
      int r = 0;
      for (int b = 0; b < LG; b++) if (k[b]) r |= 1 << (LG-1-b);
      return r;
`else
      return k;
`endif
   endfunction

   task automatic send_beat(input int v);
      int g = 0;
      in_re    = 16'(v);
      in_im    = 16'(-v);
      in_valid = 1'b1;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("in_rdy", in_ready, 1);
      @(negedge clk);
   endtask

   task automatic send_frame(input int base);
      for (int k = 0; k < LEN; k++) send_beat(base + k);
      in_valid = 1'b0;
   endtask

   task automatic core_done(input int base);
      for (int k = 0; k < LEN; k++) begin
         core_re_i[k*DW +: DW] = 16'(base + k);
         core_im_i[k*DW +: DW] = 16'(-(base + k));
      end
      core_done_i = 1'b1;
      @(negedge clk);
      core_done_i = 1'b0;
   endtask

   task automatic stream_check(input string tag, input int b0, input int b1, input int nfr);
      int g = 0;
      int base;
      logic [15:0] er, ei;
      logic lexp;
      while (!out_valid && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_start"}, out_valid, 1);
      for (int i = 0; i < nfr*LEN; i++) begin
         base = (i < LEN) ? b0 : b1;
         er   = 16'(base + lane_of(i % LEN));
         ei   = 16'(-(base + lane_of(i % LEN)));
         lexp = ((i % LEN) == LEN-1);
         chk(tag, {out_valid, out_last, out_re, out_im}, {1'b1, lexp, er, ei});
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
      core_done_i = 1'b0; core_re_i = '0; core_im_i = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_core_val", core_val_o, 0);
      chk("rst_core_data", (core_re_o == '0) && (core_im_o == '0), 1);
      chk("rst_out", {out_valid, out_last, out_re, out_im}, 0);
      chk("rst_err", err_o, 0);

      // input packing and issue timing
      snap = val_cnt;
      send_frame(0);
      chk("val_t1", core_val_o, 1);
      chk("lane15_re", core_re_o[15*DW +: DW], 16'd15);
      chk("lane15_im", core_im_o[15*DW +: DW], 16'hFFF1);
      chk("lane0_re", core_re_o[0 +: DW], 16'd0);
      chk("lane7_re", core_re_o[7*DW +: DW], 16'd7);
      repeat (3) @(negedge clk);
      chk("val_once", val_cnt - snap, 1);
      chk("core_hold", core_re_o[15*DW +: DW], 16'd15);

      // single result frame: two-edge latency, order, last marker
      out_ready = 1'b1;
      core_done(100);
      chk("lat_e0", out_valid, 0);
      @(negedge clk);
      chk("lat_e1", {out_valid, out_re}, {1'b1, 16'd100});
      stream_check("frame", 100, 100, 1);
      chk("idle_after", out_valid, 0);

      // two frames back to back, done pulses 3 cycles apart
      send_frame(16);
      send_frame(32);
      chk("cred_zero", in_ready, 0);
      fork
         begin
            core_done(300);
            repeat (2) @(negedge clk);
            core_done(400);
         end
         stream_check("b2b", 300, 400, 2);
      join
      chk("b2b_end", out_valid, 0);

      // backpressure with both banks full
      send_frame(48);
      send_frame(64);
      out_ready = 1'b0;
      core_done(500);
      core_done(550);
      repeat (3) @(negedge clk);
      chk("hold0", {out_valid, out_last, out_re}, {1'b1, 1'b0, 16'd500});
      in_valid = 1'b1; in_re = 16'h77; in_im = 16'h77;
      snap = val_cnt;
      repeat (16) @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_no_issue", val_cnt - snap, 0);
      chk("hold1", {out_valid, out_re, out_im}, {1'b1, 16'd500, 16'(-500)});
      in_valid = 1'b0;
      out_ready = 1'b1;
      stream_check("drain0", 500, 500, 1);
      chk("in_ready_back", in_ready, 1);
      stream_check("drain1", 550, 550, 1);
      chk("bp_err", err_o, 0);
      chk("bp_end", out_valid, 0);

      // overflow: third result while both banks full
      send_frame(80);
      send_frame(96);
      out_ready = 1'b0;
      core_done(600);
      core_done(700);
      core_done(900);
      chk("ovf_err", err_o, 1);
      out_ready = 1'b1;
      stream_check("ovf_keep", 600, 700, 2);
      chk("ovf_end", out_valid, 0);
      chk("err_sticky", err_o, 1);

      // reset mid-frame
      for (int k = 0; k < 7; k++) send_beat(200 + k);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_in_ready", in_ready, 1);
      chk("rst2_core", {core_val_o, (core_re_o == '0) && (core_im_o == '0)}, 2'b01);
      chk("rst2_out", {out_valid, out_last, out_re, out_im}, 0);
      chk("rst2_err", err_o, 0);
      snap = val_cnt;
      send_frame(64);
      chk("rst2_val_t1", core_val_o, 1);
      chk("rst2_lane0", core_re_o[0 +: DW], 16'd64);
      chk("rst2_lane6", core_re_o[6*DW +: DW], 16'd70);
      chk("rst2_lane15", core_re_o[15*DW +: DW], 16'd79);
      repeat (3) @(negedge clk);
      chk("rst2_val_once", val_cnt - snap, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
